// File: rtl/issue_queue_nw.sv
// Age-ordered collapsing issue queue: dispatch up to DISP_W ops, wake on WB_W tags, issue ISSUE_W oldest-ready ops.
// Latency: an op selected in cycle t appears on o_ivalid/o_iinst after edge t+1; a ready op dispatched at t issues after t+2.
// Backpressure: o_dready drops unless a whole dispatch group fits; i_stall freezes a port and its held payload.
module issue_queue_nw #(
    parameter int DEPTH     = 16,
    parameter int DISP_W    = 4,
    parameter int ISSUE_W   = 2,
    parameter int WB_W      = 4,
    parameter int WIDTH_REG = 5,
    parameter int WIDTH_TAG = 5,
    parameter int WIDTH_BRM = 3,
    parameter int WIDTH_OP  = 7,
    parameter int BR_PORT   = 0,
    localparam int E        = WIDTH_OP + WIDTH_BRM + WIDTH_TAG + 3 * WIDTH_REG,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [DISP_W-1:0]             i_dvalid,
    input  logic [DISP_W*E-1:0]           i_dinst,
    input  logic [2*DISP_W-1:0]           i_drdy,
    input  logic [DISP_W-1:0]             i_disbr,
    output logic                          o_dready,
    input  logic [WB_W-1:0]               i_wvalid,
    input  logic [WB_W*WIDTH_REG-1:0]     i_wdest,
    input  logic [WIDTH_BRM:0]            i_brkill,
    input  logic [ISSUE_W-1:0]            i_stall,
    output logic [ISSUE_W-1:0]            o_ivalid,
    output logic [ISSUE_W*E-1:0]          o_iinst,
    output logic [CW-1:0]                 o_count
);

    localparam int IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BRM_LSB = 3 * WIDTH_REG + WIDTH_TAG;
    // An out-of-range BR_PORT lets every port take branches.
    localparam bit ALL_BR  = (BR_PORT < 0) || (BR_PORT >= ISSUE_W);

    // Entry storage, index 0 oldest, valid entries packed at the bottom.
    logic [DEPTH-1:0]          ent_vld_q,  ent_vld_d;
    logic [DEPTH-1:0][E-1:0]   ent_inst_q, ent_inst_d;
    logic [DEPTH-1:0]          ent_r1_q,   ent_r1_d;
    logic [DEPTH-1:0]          ent_r2_q,   ent_r2_d;
    logic [DEPTH-1:0]          ent_br_q,   ent_br_d;
    // Registered issue ports.
    logic [ISSUE_W-1:0]        iss_vld_q,  iss_vld_d;
    logic [ISSUE_W-1:0][E-1:0] iss_inst_q, iss_inst_d;
    logic [CW-1:0]             count_q,    count_d;

    logic [DEPTH-1:0]          ent_kill;
    logic [DEPTH-1:0]          ent_elig;
    logic [DEPTH-1:0]          taken;
    logic [ISSUE_W-1:0]        sel_vld;
    logic [ISSUE_W-1:0][E-1:0] sel_inst;
    logic                      dready;

    // True when the kill bus is active and shares a branch-mask bit with this payload.
    function automatic logic kill_hit(input logic [E-1:0] inst, input logic [WIDTH_BRM:0] brkill);
        return brkill[WIDTH_BRM] && (|(inst[BRM_LSB +: WIDTH_BRM] & brkill[WIDTH_BRM-1:0]));
    endfunction

    // True when any valid writeback lane carries this source tag.
    function automatic logic wake_hit(input logic [WIDTH_REG-1:0] rs,
                                      input logic [WB_W-1:0] wvld,
                                      input logic [WB_W*WIDTH_REG-1:0] wdest);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < WB_W; w++) begin
            if (wvld[w] && (wdest[w*WIDTH_REG +: WIDTH_REG] == rs)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Accept a group only when the registered count leaves room for all lanes.
    assign dready   = (CW'(DEPTH) - count_q) >= CW'(DISP_W);
    assign o_dready = dready;
    assign o_count  = count_q;
    assign o_ivalid = iss_vld_q;
    assign o_iinst  = iss_inst_q;

    // Kill matching and eligibility use stored ready bits, so wakeups count from the next cycle.
    always_comb begin
        ent_kill = '0;
        ent_elig = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_kill[i] = ent_vld_q[i] && kill_hit(ent_inst_q[i], i_brkill);
            ent_elig[i] = ent_vld_q[i] && !ent_kill[i] && ent_r1_q[i] && ent_r2_q[i];
        end
    end

    // Fill non-stalled ports in ascending order with the oldest eligible entries; only branch-capable ports take branches.
    always_comb begin
        taken    = '0;
        sel_vld  = '0;
        sel_inst = '0;
        for (int p = 0; p < ISSUE_W; p++) begin
            if (!i_stall[p]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!sel_vld[p] && ent_elig[i] && !taken[i] &&
                        (ALL_BR || (p == BR_PORT) || !ent_br_q[i])) begin
                        sel_vld[p]  = 1'b1;
                        sel_inst[p] = ent_inst_q[i];
                        taken[i]    = 1'b1;
                    end
                end
            end
        end
    end

    // Stalled ports hold their payload but still drop it on a matching kill; free ports load the new selection.
    always_comb begin
        iss_vld_d  = '0;
        iss_inst_d = '0;
        for (int p = 0; p < ISSUE_W; p++) begin
            if (i_stall[p]) begin
                iss_vld_d[p]  = iss_vld_q[p] && !kill_hit(iss_inst_q[p], i_brkill);
                iss_inst_d[p] = iss_inst_q[p];
            end else begin
                iss_vld_d[p]  = sel_vld[p];
                iss_inst_d[p] = sel_inst[p];
            end
        end
    end

    // Drop killed and issued entries, collapse survivors toward index 0, then append surviving dispatch lanes.
    always_comb begin
        logic [CW-1:0] pos;
        logic [E-1:0]  lane_inst;
        ent_vld_d  = '0;
        ent_inst_d = '0;
        ent_r1_d   = '0;
        ent_r2_d   = '0;
        ent_br_d   = '0;
        pos        = '0;
        lane_inst  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld_q[i] && !ent_kill[i] && !taken[i]) begin
                ent_vld_d[pos[IW-1:0]]  = 1'b1;
                ent_inst_d[pos[IW-1:0]] = ent_inst_q[i];
                ent_r1_d[pos[IW-1:0]]   = ent_r1_q[i] ||
                    wake_hit(ent_inst_q[i][WIDTH_REG +: WIDTH_REG], i_wvalid, i_wdest);
                ent_r2_d[pos[IW-1:0]]   = ent_r2_q[i] ||
                    wake_hit(ent_inst_q[i][0 +: WIDTH_REG], i_wvalid, i_wdest);
                ent_br_d[pos[IW-1:0]]   = ent_br_q[i];
                pos = pos + CW'(1);
            end
        end
        if (dready) begin
            for (int k = 0; k < DISP_W; k++) begin
                lane_inst = i_dinst[k*E +: E];
                if (i_dvalid[k] && !kill_hit(lane_inst, i_brkill) && (pos < CW'(DEPTH))) begin
                    ent_vld_d[pos[IW-1:0]]  = 1'b1;
                    ent_inst_d[pos[IW-1:0]] = lane_inst;
                    ent_r1_d[pos[IW-1:0]]   = i_drdy[2*k] ||
                        wake_hit(lane_inst[WIDTH_REG +: WIDTH_REG], i_wvalid, i_wdest);
                    ent_r2_d[pos[IW-1:0]]   = i_drdy[2*k+1] ||
                        wake_hit(lane_inst[0 +: WIDTH_REG], i_wvalid, i_wdest);
                    ent_br_d[pos[IW-1:0]]   = i_disbr[k];
                    pos = pos + CW'(1);
                end
            end
        end
        count_d = pos;
    end

    // State registers; reset wins over dispatch, issue and kill.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ent_vld_q  <= '0;
            ent_inst_q <= '0;
            ent_r1_q   <= '0;
            ent_r2_q   <= '0;
            ent_br_q   <= '0;
            iss_vld_q  <= '0;
            iss_inst_q <= '0;
            count_q    <= '0;
        end else begin
            ent_vld_q  <= ent_vld_d;
            ent_inst_q <= ent_inst_d;
            ent_r1_q   <= ent_r1_d;
            ent_r2_q   <= ent_r2_d;
            ent_br_q   <= ent_br_d;
            iss_vld_q  <= iss_vld_d;
            iss_inst_q <= iss_inst_d;
            count_q    <= count_d;
        end
    end

endmodule
